// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and defaults for the external memory bus arbiter.
// Pure declarations; no timing or flow-control behaviour of its own.
// Consumers import the whole package.
package mem_bus_arbiter_pkg;

    localparam logic [2:0] ARB_IDLE   = 3'd0;
    localparam logic [2:0] ARB_BUSY_D = 3'd1;
    localparam logic [2:0] ARB_BUSY_I = 3'd2;
    localparam logic [2:0] ARB_RESP_D = 3'd3;
    localparam logic [2:0] ARB_RESP_I = 3'd4;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        WRITE_ENABLE = 1'b1;

    localparam int TIMEOUT_CYC_DEF = 255;

    // Everything the bus sees for one transaction, latched on BUSY entry.
    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ARB_BUSY_D) || (st == ARB_BUSY_I);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Busy-cycle watchdog for one bus transaction; counter cleared on load.
// expire is combinational on the TIMEOUT_CYC-th enabled cycle.
// No backpressure; the counter saturates instead of wrapping.
module arb_timeout_cnt #(
    parameter int TO_W        = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [TO_W-1:0] LIMIT   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] CNT_MAX = '1;

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q counts completed busy cycles, so LIMIT marks the last allowed one.
    assign expire = en && (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between the fetch port and the data port, data first.
// Latency: ack in the first busy cycle gives ready two edges after the request is sampled.
// Backpressure: stall_req_o holds the pipeline while any enabled port lacks a response.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = 8
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        flush_i,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        stall_req_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    logic [2:0]  state_q;
    logic [2:0]  state_nxt;
    bus_cmd_t    cmd_q;
    logic        disc_q;
    logic        d_done_q;
    logic        i_done_q;
    logic [31:0] d_rdata_q;
    logic [31:0] i_rdata_q;
    logic        err_q;

    logic d_pend;
    logic i_pend;
    logic busy;
    logic to_expire;
    logic done_now;
    logic start_d;
    logic start_i;

    assign d_pend      = (mem_ce_i == CHIP_ENABLE) && !d_done_q;
    assign i_pend      = (if_ce_i == CHIP_ENABLE) && !i_done_q;
    assign stall_req_o = d_pend || i_pend;

    assign busy     = is_busy(state_q);
    assign done_now = busy && (bus_ack_i || to_expire);

    // A flush in IDLE suppresses arbitration for that cycle only.
    assign start_d = (state_q == ARB_IDLE) && !flush_i && d_pend;
    assign start_i = (state_q == ARB_IDLE) && !flush_i && !d_pend && i_pend;

    arb_timeout_cnt #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk    (cpu_clk_50M),
        .rst    (cpu_rst),
        .load   (start_d || start_i),
        .en     (busy),
        .expire (to_expire)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (start_d) begin
                    state_nxt = ARB_BUSY_D;
                end else if (start_i) begin
                    state_nxt = ARB_BUSY_I;
                end
            end
            ARB_BUSY_D: if (done_now) state_nxt = ARB_RESP_D;
            ARB_BUSY_I: if (done_now) state_nxt = ARB_RESP_I;
            ARB_RESP_D: state_nxt = ARB_IDLE;
            ARB_RESP_I: state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q   <= ARB_IDLE;
            cmd_q     <= '0;
            disc_q    <= 1'b0;
            d_done_q  <= 1'b0;
            i_done_q  <= 1'b0;
            d_rdata_q <= ZERO_WORD;
            i_rdata_q <= ZERO_WORD;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_nxt;

            if (start_d) begin
                cmd_q.we    <= mem_we_i;
                cmd_q.sel   <= mem_sel_i;
                cmd_q.addr  <= mem_addr_i;
                cmd_q.wdata <= mem_wdata_i;
            end else if (start_i) begin
                cmd_q.we    <= 1'b0;
                cmd_q.sel   <= 4'b1111;
                cmd_q.addr  <= if_addr_i;
                cmd_q.wdata <= ZERO_WORD;
            end

            // A bus cycle in flight cannot be aborted; a flush only marks its result as dead.
            if (start_d || start_i) begin
                disc_q <= 1'b0;
            end else if (busy && flush_i) begin
                disc_q <= 1'b1;
            end

            err_q <= busy && !bus_ack_i && to_expire;

            if ((state_q == ARB_BUSY_D) && done_now) begin
                d_rdata_q <= (bus_ack_i && (cmd_q.we != WRITE_ENABLE)) ? bus_rdata_i : ZERO_WORD;
            end
            if ((state_q == ARB_BUSY_I) && done_now) begin
                i_rdata_q <= bus_ack_i ? bus_rdata_i : ZERO_WORD;
            end

            if (flush_i || !stall_req_o) begin
                d_done_q <= 1'b0;
                i_done_q <= 1'b0;
            end
            if ((state_q == ARB_RESP_D) && !disc_q && !flush_i) begin
                d_done_q <= 1'b1;
            end
            if ((state_q == ARB_RESP_I) && !disc_q && !flush_i) begin
                i_done_q <= 1'b1;
            end
        end
    end

    assign bus_req_o   = busy;
    assign bus_we_o    = cmd_q.we;
    assign bus_sel_o   = cmd_q.sel;
    assign bus_addr_o  = cmd_q.addr;
    assign bus_wdata_o = cmd_q.wdata;
    assign bus_err_o   = err_q;

    assign mem_ready_o = d_done_q;
    assign mem_rdata_o = d_rdata_q;
    assign if_ready_o  = i_done_q;
    assign if_data_o   = i_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of single transactions plus
// hand-written contention, flush, timeout and async-reset sequences.
module tb_mem_bus_arbiter;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst     = 1'b1;
    logic        flush_i     = 1'b0;
    logic        if_ce_i     = 1'b0;
    logic [31:0] if_addr_i   = '0;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        mem_ce_i    = 1'b0;
    logic        mem_we_i    = 1'b0;
    logic [3:0]  mem_sel_i   = '0;
    logic [31:0] mem_addr_i  = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;
    logic        stall_req_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i   = 1'b0;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.TIMEOUT_CYC(255), .TO_W(8)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .flush_i     (flush_i),
        .if_ce_i     (if_ce_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ready_o  (if_ready_o),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_sel_i   (mem_sel_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ready_o (mem_ready_o),
        .stall_req_o (stall_req_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_sel_o   (bus_sel_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .bus_err_o   (bus_err_o)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    typedef struct {
        logic        is_if;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          k;
        int          busy_n;
        int          unstable;
        int          errs;
        logic        rdy;
        logic        first_we;
        logic [3:0]  first_sel;
        logic [31:0] first_addr;
        logic [31:0] first_wdata;
        k = 0; busy_n = 0; unstable = 0; errs = 0; rdy = 1'b0;
        first_we = 1'b0; first_sel = '0; first_addr = '0; first_wdata = '0;
        mem_ce_i    = !v.is_if;
        if_ce_i     = v.is_if;
        mem_we_i    = v.we;
        mem_sel_i   = v.sel;
        mem_addr_i  = v.addr;
        mem_wdata_i = v.wdata;
        if_addr_i   = v.addr;
        #1;
        chk($sformatf("v%0d stall_on_req", idx), {31'b0, stall_req_o}, 32'd1);
        while (k < 30) begin
            step();
            bus_ack_i   = 1'b0;
            bus_rdata_i = '0;
            rdy = v.is_if ? if_ready_o : mem_ready_o;
            if (rdy) break;
            if (bus_err_o) errs++;
            if (bus_req_o) begin
                if (busy_n == 0) begin
                    first_we = bus_we_o; first_sel = bus_sel_o;
                    first_addr = bus_addr_o; first_wdata = bus_wdata_o;
                end else if (bus_we_o !== first_we || bus_sel_o !== first_sel ||
                             bus_addr_o !== first_addr || bus_wdata_o !== first_wdata) begin
                    unstable++;
                end
                if (busy_n == v.dly) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = v.rdata;
                end
                busy_n++;
            end
            k++;
        end
        chk($sformatf("v%0d latency", idx), 32'(k), 32'(v.exp_lat));
        chk($sformatf("v%0d ready", idx), {31'b0, rdy}, 32'd1);
        chk($sformatf("v%0d bus_addr", idx), first_addr, v.addr);
        chk($sformatf("v%0d bus_we", idx), {31'b0, first_we}, {31'b0, v.exp_we});
        chk($sformatf("v%0d bus_sel", idx), {28'b0, first_sel}, {28'b0, v.exp_sel});
        if (!v.is_if) chk($sformatf("v%0d bus_wdata", idx), first_wdata, v.wdata);
        chk($sformatf("v%0d rdata", idx), v.is_if ? if_data_o : mem_rdata_o, v.exp_rdata);
        chk($sformatf("v%0d stall_after", idx), {31'b0, stall_req_o}, 32'd0);
        chk($sformatf("v%0d unstable", idx), 32'(unstable), 32'd0);
        chk($sformatf("v%0d err_pulses", idx), 32'(errs), 32'd0);
        mem_ce_i = 1'b0;
        if_ce_i  = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          ntx;
        int          gap;
        int          rdy_seen;
        int          req_cyc;
        int          err_cyc;
        int          err_with_req;
        logic [31:0] tx_addr[2];

        vecs[0] = '{1'b0, 1'b0, 4'hF,    32'h0000_0104, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, 4'hF,    32'hDEAD_BEEF, 5};
        vecs[1] = '{1'b0, 1'b1, 4'b0100, 32'h0000_0200, 32'h00AB_0000, 1, 32'h1234_5678, 1'b1, 4'b0100, 32'h0000_0000, 3};
        vecs[2] = '{1'b1, 1'b1, 4'b0011, 32'h0000_1000, 32'hFFFF_FFFF, 0, 32'h2408_0001, 1'b0, 4'hF,    32'h2408_0001, 2};
        vecs[3] = '{1'b1, 1'b0, 4'hF,    32'hBFC0_0000, 32'h0000_0000, 2, 32'h3C08_BFC0, 1'b0, 4'hF,    32'h3C08_BFC0, 4};
        vecs[4] = '{1'b0, 1'b0, 4'b0001, 32'h0000_0303, 32'h0000_0000, 0, 32'h0000_00AA, 1'b0, 4'b0001, 32'h0000_00AA, 2};

        step();
        step();
        chk("rst bus_req", {31'b0, bus_req_o}, 32'd0);
        chk("rst mem_ready", {31'b0, mem_ready_o}, 32'd0);
        chk("rst if_ready", {31'b0, if_ready_o}, 32'd0);
        chk("rst bus_err", {31'b0, bus_err_o}, 32'd0);
        chk("rst bus_addr", bus_addr_o, 32'h0);
        chk("rst mem_rdata", mem_rdata_o, 32'h0);
        cpu_rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Contention: data goes first, then fetch.
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h40;
        if_ce_i  = 1'b1; if_addr_i = 32'h80;
        k = 0; ntx = 0; tx_addr[0] = '0; tx_addr[1] = '0;
        while (k < 20) begin
            step();
            bus_ack_i = 1'b0;
            if (!stall_req_o) break;
            if (bus_req_o) begin
                if (ntx < 2) tx_addr[ntx] = bus_addr_o;
                ntx++;
                bus_ack_i   = 1'b1;
                bus_rdata_i = (bus_addr_o == 32'h40) ? 32'h1111_1111 : 32'h2222_2222;
            end
            k++;
        end
        chk("cont edges_to_release", 32'(k), 32'd5);
        chk("cont txn_count", 32'(ntx), 32'd2);
        chk("cont first_addr", tx_addr[0], 32'h40);
        chk("cont second_addr", tx_addr[1], 32'h80);
        chk("cont mem_rdata", mem_rdata_o, 32'h1111_1111);
        chk("cont if_data", if_data_o, 32'h2222_2222);
        chk("cont both_ready", {30'b0, mem_ready_o, if_ready_o}, 32'd3);
        chk("cont bus_req_at_release", {31'b0, bus_req_o}, 32'd0);
        step();
        chk("cont stall_back", {31'b0, stall_req_o}, 32'd1);
        chk("cont ready_cleared", {31'b0, mem_ready_o}, 32'd0);
        chk("cont no_reissue", {31'b0, bus_req_o}, 32'd0);
        mem_ce_i = 1'b0; if_ce_i = 1'b0;
        step();
        step();
        chk("cont idle_after", {31'b0, bus_req_o}, 32'd0);

        // Flush during BUSY_I: result discarded, new fetch restarts from IDLE.
        if_ce_i = 1'b1; if_addr_i = 32'h300;
        k = 0;
        while (k < 10) begin
            step();
            if (bus_req_o) break;
            k++;
        end
        chk("flush busy_reached", {31'b0, bus_req_o}, 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush req_held1", {31'b0, bus_req_o}, 32'd1);
        step();
        chk("flush req_held2", {31'b0, bus_req_o}, 32'd1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h9999_0000; if_addr_i = 32'h380;
        step();
        bus_ack_i = 1'b0;
        gap = 0; rdy_seen = 0; k = 0;
        while (k < 10 && !bus_req_o) begin
            if (if_ready_o) rdy_seen++;
            gap++;
            step();
            k++;
        end
        chk("flush no_ready", 32'(rdy_seen), 32'd0);
        chk("flush gap", 32'(gap), 32'd2);
        chk("flush new_addr", bus_addr_o, 32'h380);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
        step();
        bus_ack_i = 1'b0;
        step();
        chk("flush new_ready", {31'b0, if_ready_o}, 32'd1);
        chk("flush new_data", if_data_o, 32'h5555_AAAA);
        if_ce_i = 1'b0;
        step();

        // Flush in IDLE blocks arbitration; flush with ack discards.
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h500; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("idleflush blocked", {31'b0, bus_req_o}, 32'd0);
        step();
        chk("idleflush start", {31'b0, bus_req_o}, 32'd1);
        step();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h7777_7777; flush_i = 1'b1; mem_ce_i = 1'b0;
        step();
        bus_ack_i = 1'b0; flush_i = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_ready_o || bus_req_o) rdy_seen++;
            step();
        end
        chk("ackflush discarded", 32'(rdy_seen), 32'd0);

        // Timeout: no ack ever.
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h600;
        req_cyc = 0; err_cyc = 0; err_with_req = 0; k = 0;
        while (k < 400) begin
            step();
            if (mem_ready_o) break;
            if (bus_req_o) req_cyc++;
            if (bus_err_o) begin
                err_cyc++;
                if (bus_req_o) err_with_req++;
            end
            k++;
        end
        chk("to busy_cycles", 32'(req_cyc), 32'd255);
        chk("to err_pulse", 32'(err_cyc), 32'd1);
        chk("to req_fell", 32'(err_with_req), 32'd0);
        chk("to ready", {31'b0, mem_ready_o}, 32'd1);
        chk("to rdata", mem_rdata_o, 32'h0);
        mem_ce_i = 1'b0;
        step();

        // Async reset while BUSY_D, with a fetch response still held.
        if_ce_i = 1'b1; if_addr_i = 32'h700;
        step();
        chk("ar fetch_busy", {31'b0, bus_req_o}, 32'd1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_0001;
        step();
        bus_ack_i = 1'b0;
        step();
        chk("ar if_ready", {31'b0, if_ready_o}, 32'd1);
        mem_ce_i = 1'b1; mem_addr_i = 32'h704;
        step();
        chk("ar busy_d", {31'b0, bus_req_o}, 32'd1);
        #2;
        cpu_rst = 1'b1;
        #1;
        chk("ar bus_req", {31'b0, bus_req_o}, 32'd0);
        chk("ar if_ready_clr", {31'b0, if_ready_o}, 32'd0);
        chk("ar mem_ready_clr", {31'b0, mem_ready_o}, 32'd0);
        chk("ar if_data_clr", if_data_o, 32'h0);
        mem_ce_i = 1'b0; if_ce_i = 1'b0;
        step();
        cpu_rst = 1'b0;
        step();
        step();
        chk("ar stays_idle", {31'b0, bus_req_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
